// File: rtl/atan_arbiter_if.sv
// Requester/response bus of atan_arbiter: N packed (x, y) request lanes plus the tagged result strobe.
// master = requesters and result consumer, slave = the arbiter.
interface atan_arbiter_if #(
    parameter int N     = 4,
    parameter int width = 10
);
    logic [N-1:0]         req_valid;
    logic [N*width-1:0]   req_x;
    logic [N*width-1:0]   req_y;
    logic [N-1:0]         req_ready;
    logic                 pause;
    logic                 resp_valid;
    logic [$clog2(N)-1:0] resp_id;
    logic [11:0]          resp_degree;
    logic                 resp_err;
    logic                 busy;

    modport master (
        output req_valid, req_x, req_y, pause,
        input  req_ready, resp_valid, resp_id, resp_degree, resp_err, busy
    );

    modport slave (
        input  req_valid, req_x, req_y, pause,
        output req_ready, resp_valid, resp_id, resp_degree, resp_err, busy
    );
endinterface

// File: rtl/atan_arbiter.sv
// Round-robin scheduler sharing one clocked atan core between N requesters, returning id-tagged angles.
// Define ATAN_ARB_ZERO_CHK_EN to flag zero vectors (resp_err=1, resp_degree=0); otherwise resp_err stays 0.
module atan_arbiter #(
    parameter int N        = 4,
    parameter int width    = 10,
    parameter int ATAN_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    atan_arbiter_if.slave           bus,
    output logic signed [width-1:0] atan_x,
    output logic signed [width-1:0] atan_y,
    input  logic [11:0]             atan_degree
);
    localparam int ID_W  = $clog2(N);
    localparam int DEPTH = ATAN_LAT + 1;
    localparam int CNT_W = $clog2(ATAN_LAT + 2);

    logic [ID_W-1:0]               ptr_q, ptr_d;
    logic [N-1:0]                  grant;
    logic [ID_W-1:0]               gnt_idx;
    logic                          gnt_found;
    logic                          transfer;
    logic signed [width-1:0]       sel_x, sel_y;
    logic                          sel_err;

    logic signed [width-1:0]       atan_x_q, atan_x_d;
    logic signed [width-1:0]       atan_y_q, atan_y_d;

    // Tag stage 0 sits alongside the issue register; the last stage lines up with atan_degree.
    logic [DEPTH-1:0]              tag_vld_q, tag_vld_d;
    logic [DEPTH-1:0][ID_W-1:0]    tag_id_q, tag_id_d;
    logic [DEPTH-1:0]              tag_err_q, tag_err_d;

    logic                          resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]               resp_id_q, resp_id_d;
    logic [11:0]                   resp_degree_q, resp_degree_d;
    logic                          resp_err_q, resp_err_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;

    // First valid requester searching from ptr upward, wrapping at N.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!gnt_found && bus.req_valid[ID_W'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
            end
        end
        if (gnt_found && !bus.pause && !rst) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign transfer = |(bus.req_valid & grant);

    always_comb begin
        sel_x   = bus.req_x[gnt_idx*width +: width];
        sel_y   = bus.req_y[gnt_idx*width +: width];
`ifdef ATAN_ARB_ZERO_CHK_EN
        sel_err = (sel_x == '0) && (sel_y == '0);
`else
        sel_err = 1'b0;
`endif
    end

    always_comb begin
        ptr_d    = ptr_q;
        atan_x_d = atan_x_q;
        atan_y_d = atan_y_q;
        if (transfer) begin
            atan_x_d = sel_x;
            atan_y_d = sel_y;
            if (gnt_idx == ID_W'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
        end

        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_err_d    = '0;
        tag_vld_d[0] = transfer;
        tag_id_d[0]  = transfer ? gnt_idx : '0;
        tag_err_d[0] = transfer & sel_err;
        for (int j = 1; j < DEPTH; j++) begin
            tag_vld_d[j] = tag_vld_q[j-1];
            tag_id_d[j]  = tag_id_q[j-1];
            tag_err_d[j] = tag_err_q[j-1];
        end
    end

    // Results are captured when a live tag leaves the pipeline; other fields hold between strobes.
    always_comb begin
        resp_valid_d  = tag_vld_q[DEPTH-1];
        resp_id_d     = resp_id_q;
        resp_degree_d = resp_degree_q;
        resp_err_d    = resp_err_q;
        if (tag_vld_q[DEPTH-1]) begin
            resp_id_d     = tag_id_q[DEPTH-1];
            resp_err_d    = tag_err_q[DEPTH-1];
            resp_degree_d = tag_err_q[DEPTH-1] ? 12'd0 : atan_degree;
        end

        cnt_d = cnt_q;
        if (transfer && !resp_valid_d) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!transfer && resp_valid_d) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q         <= '0;
            atan_x_q      <= '0;
            atan_y_q      <= '0;
            tag_vld_q     <= '0;
            tag_id_q      <= '0;
            tag_err_q     <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_degree_q <= '0;
            resp_err_q    <= 1'b0;
            cnt_q         <= '0;
        end else begin
            ptr_q         <= ptr_d;
            atan_x_q      <= atan_x_d;
            atan_y_q      <= atan_y_d;
            tag_vld_q     <= tag_vld_d;
            tag_id_q      <= tag_id_d;
            tag_err_q     <= tag_err_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_degree_q <= resp_degree_d;
            resp_err_q    <= resp_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.req_ready   = grant;
    assign atan_x          = atan_x_q;
    assign atan_y          = atan_y_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_degree = resp_degree_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.busy        = (cnt_q != '0) | resp_valid_q;
endmodule

// File: tb/tb_atan_arbiter.sv
// Scoreboard bench for atan_arbiter (N=4, ATAN_LAT=1) with a behavioural 1-cycle atan core.
// Zero-vector expectations follow ATAN_ARB_ZERO_CHK_EN.
module tb_atan_arbiter;
    localparam int N = 4;
    localparam int W = 10;
`ifdef ATAN_ARB_ZERO_CHK_EN
    localparam int ZERO_ERR = 1;
`else
    localparam int ZERO_ERR = 0;
`endif

    typedef struct {
        int id;
        int deg;
        int err;
        int cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [W-1:0] atan_x;
    logic signed [W-1:0] atan_y;
    logic [11:0]         core_deg;
    int                  cyc = 0;
    int                  checks = 0;
    int                  errors = 0;
    exp_t                sb[$];
    logic signed [W-1:0] vx[N];
    logic signed [W-1:0] vy[N];

    atan_arbiter_if #(.N(N), .width(W)) bus ();

    atan_arbiter #(.N(N), .width(W), .ATAN_LAT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .atan_x      (atan_x),
        .atan_y      (atan_y),
        .atan_degree (core_deg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic int refAngle(input int x, input int y);
        real r;
        int  d;
        r = $atan2(real'(y), real'(x)) * 1800.0 / 3.14159265358979;
        if (r < 0.0) r = r + 3600.0;
        d = int'(r);
        if (d >= 3600) d = d - 3600;
        return d;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) core_deg <= 12'd0;
        else     core_deg <= 12'(refAngle(int'(atan_x), int'(atan_y)));
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] valid, input logic p);
        for (int i = 0; i < N; i++) begin
            bus.req_x[i*W +: W] = vx[i];
            bus.req_y[i*W +: W] = vy[i];
        end
        bus.req_valid = valid;
        bus.pause     = p;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expect requester id to be granted now; its response is due three edges from this half-cycle.
    task automatic grantStep(input int id, input int deg, input int err);
        exp_t e;
        #1;
        checkOutput("grant", int'(bus.req_ready), 1 << id);
        e.id  = id;
        e.deg = deg;
        e.err = err;
        e.cyc = cyc + 3;
        sb.push_back(e);
        nextCycle();
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        #1;
        while ((sb.size() != 0 || bus.busy !== 1'b0) && n < 20) begin
            nextCycle();
            #1;
            n++;
        end
        checkOutput("drain_pending", sb.size(), 0);
        checkOutput("drain_busy", int'(bus.busy), 0);
    endtask

    // Monitor: every result strobe must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL resp_unexpected: got id %0d degree %0d, expected no response (cycle %0d)",
                         bus.resp_id, bus.resp_degree, cyc);
            end else begin
                e = sb.pop_front();
                checkOutput("resp_id", int'(bus.resp_id), e.id);
                checkOutput("resp_degree", int'(bus.resp_degree), e.deg);
                checkOutput("resp_err", int'(bus.resp_err), e.err);
                checkOutput("resp_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            vx[i] = '0;
            vy[i] = '0;
        end
        vx[0] = 10'sd100;
        applyStimulus(4'b1111, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", int'(bus.req_ready), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_resp_valid", int'(bus.resp_valid), 0);
        checkOutput("rst_resp_id", int'(bus.resp_id), 0);
        checkOutput("rst_resp_degree", int'(bus.resp_degree), 0);
        checkOutput("rst_resp_err", int'(bus.resp_err), 0);
        checkOutput("rst_atan_x", int'(atan_x), 0);
        checkOutput("rst_atan_y", int'(atan_y), 0);
        applyStimulus(4'b0000, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_busy", int'(bus.busy), 0);

        $display("[TB] single request from requester 2");
        @(negedge clk);
        vx[2] = 10'sd0;
        vy[2] = 10'sd100;
        applyStimulus(4'b0100, 1'b0);
        grantStep(2, 900, 0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("issue_atan_x", int'(atan_x), 0);
        checkOutput("issue_atan_y", int'(atan_y), 100);
        checkOutput("single_busy_k", int'(bus.busy), 1);
        nextCycle();
        checkOutput("single_busy_k1", int'(bus.busy), 1);
        nextCycle();
        checkOutput("single_busy_pulse", int'(bus.busy), 1);
        nextCycle();
        checkOutput("single_busy_done", int'(bus.busy), 0);

        $display("[TB] pointer wrap with requesters 3 and 1");
        vx[1] = 10'sd100;  vy[1] = 10'sd100;
        vx[3] = 10'sd0;    vy[3] = -10'sd100;
        applyStimulus(4'b1010, 1'b0);
        grantStep(3, 2700, 0);
        grantStep(1, 450, 0);
        grantStep(3, 2700, 0);
        applyStimulus(4'b0000, 1'b0);
        drain();

        $display("[TB] fairness with all requesters");
        pulseReset();
        vx[0] = 10'sd100;  vy[0] = 10'sd0;
        vx[1] = 10'sd0;    vy[1] = 10'sd100;
        vx[2] = -10'sd100; vy[2] = 10'sd0;
        vx[3] = 10'sd0;    vy[3] = -10'sd100;
        applyStimulus(4'b1111, 1'b0);
        grantStep(0, 0, 0);
        grantStep(1, 900, 0);
        grantStep(2, 1800, 0);
        grantStep(3, 2700, 0);
        grantStep(0, 0, 0);
        applyStimulus(4'b0000, 1'b0);
        drain();

        $display("[TB] pause mid-stream");
        pulseReset();
        vx[0] = 10'sd100;  vy[0] = 10'sd100;
        vx[1] = -10'sd100; vy[1] = 10'sd100;
        applyStimulus(4'b0011, 1'b0);
        grantStep(0, 450, 0);
        applyStimulus(4'b0011, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("pause_ready", int'(bus.req_ready), 0);
            nextCycle();
        end
        checkOutput("pause_busy_drop", int'(bus.busy), 0);
        applyStimulus(4'b0011, 1'b0);
        grantStep(1, 1350, 0);
        applyStimulus(4'b0000, 1'b0);
        drain();

        $display("[TB] reset mid-flight");
        vx[0] = 10'sd100;  vy[0] = 10'sd0;
        vx[2] = 10'sd0;    vy[2] = 10'sd100;
        applyStimulus(4'b0100, 1'b0);
        #1;
        checkOutput("midrst_grant", int'(bus.req_ready), 4'b0100);
        nextCycle();
        applyStimulus(4'b1111, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_ready_forced", int'(bus.req_ready), 0);
        checkOutput("midrst_busy", int'(bus.busy), 0);
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("midrst_busy_after", int'(bus.busy), 0);
        grantStep(0, 0, 0);
        applyStimulus(4'b0000, 1'b0);
        drain();

        $display("[TB] zero vector from requester 1");
        vx[1] = 10'sd0;    vy[1] = 10'sd0;
        applyStimulus(4'b0010, 1'b0);
        grantStep(1, 0, ZERO_ERR);
        applyStimulus(4'b0000, 1'b0);
        drain();

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
